// File: rtl/rf_wb_if.sv
// Issue, ALU/LSU write-back and register-file write bundle for rf_wb_scoreboard.
interface rf_wb_if #(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 5
);
  logic                      iss_valid;
  logic [A_WIDTH-1:0]        iss_rs1;
  logic [A_WIDTH-1:0]        iss_rs2;
  logic                      iss_use1;
  logic                      iss_use2;
  logic                      iss_wr;
  logic [A_WIDTH-1:0]        iss_rd;
  logic                      iss_ready;

  logic                      alu_valid;
  logic [A_WIDTH-1:0]        alu_rd;
  logic [D_WIDTH-1:0]        alu_data;
  logic                      alu_ready;

  logic                      lsu_valid;
  logic [A_WIDTH-1:0]        lsu_rd;
  logic [D_WIDTH-1:0]        lsu_data;
  logic                      lsu_ready;

  logic                      rf_we;
  logic [A_WIDTH-1:0]        rf_waddr;
  logic [D_WIDTH-1:0]        rf_wdata;
  logic [(1<<A_WIDTH)-1:0]   busy_mask;
  logic                      wb_err;

  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_use1, iss_use2, iss_wr, iss_rd,
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  iss_ready, alu_ready, lsu_ready,
    input  rf_we, rf_waddr, rf_wdata, busy_mask, wb_err
  );

  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_use1, iss_use2, iss_wr, iss_rd,
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output iss_ready, alu_ready, lsu_ready,
    output rf_we, rf_waddr, rf_wdata, busy_mask, wb_err
  );
endinterface

// File: rtl/rf_wb_scoreboard.sv
// RAW/WAW scoreboard plus round-robin ALU/LSU arbiter for the single RF write port.
// Grant in N -> registered RF write in N+1, busy clears at end of N+1; losers hold until ready.
module rf_wb_scoreboard #(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  rf_wb_if.slave     bus
);
  localparam int NREG = 1 << A_WIDTH;

  logic [NREG-1:0]    busy_q;
  logic [NREG-1:0]    busy_n;
  logic               last_lsu_q;
  logic               rf_we_q;
  logic [A_WIDTH-1:0] rf_waddr_q;
  logic [D_WIDTH-1:0] rf_wdata_q;
  logic               wb_err_q;

  logic               hazard_free;
  logic               iss_fire;
  logic               grant_alu;
  logic               grant_lsu;
  logic               grant;
  logic [A_WIDTH-1:0] wb_rd;
  logic [D_WIDTH-1:0] wb_data;

  // busy_q[0] is never set, so x0 reads and writes never stall.
  always_comb begin
    hazard_free = 1'b1;
    if (bus.iss_use1 && busy_q[bus.iss_rs1]) hazard_free = 1'b0;
    if (bus.iss_use2 && busy_q[bus.iss_rs2]) hazard_free = 1'b0;
    if (bus.iss_wr   && busy_q[bus.iss_rd])  hazard_free = 1'b0;
  end

  assign iss_fire  = bus.iss_valid & bus.iss_ready;

  // On a tie the requester that did not win last time is granted.
  assign grant_alu = rst_n & bus.alu_valid & (~bus.lsu_valid | last_lsu_q);
  assign grant_lsu = rst_n & bus.lsu_valid & (~bus.alu_valid | ~last_lsu_q);
  assign grant     = grant_alu | grant_lsu;
  assign wb_rd     = grant_alu ? bus.alu_rd   : bus.lsu_rd;
  assign wb_data   = grant_alu ? bus.alu_data : bus.lsu_data;

  always_comb begin
    busy_n = busy_q;
    if (rf_we_q) busy_n[rf_waddr_q] = 1'b0;
    if (iss_fire && bus.iss_wr && (bus.iss_rd != '0)) busy_n[bus.iss_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q     <= '0;
      last_lsu_q <= 1'b1;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      busy_q  <= busy_n;
      rf_we_q <= grant && (wb_rd != '0);
      if (grant) begin
        rf_waddr_q <= wb_rd;
        rf_wdata_q <= wb_data;
        last_lsu_q <= grant_lsu;
        if ((wb_rd != '0) && !busy_q[wb_rd]) wb_err_q <= 1'b1;
      end
    end
  end

  assign bus.iss_ready = rst_n & hazard_free;
  assign bus.alu_ready = grant_alu;
  assign bus.lsu_ready = grant_lsu;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.busy_mask = busy_q;
  assign bus.wb_err    = wb_err_q;
endmodule

// File: tb/tb_rf_wb_scoreboard.sv
// Directed self-checking bench for rf_wb_scoreboard: reset, tie arbitration, RAW, x0, WAW/wb_err, mid-op reset.
module tb_rf_wb_scoreboard;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  rf_wb_if #(.D_WIDTH(32), .A_WIDTH(5)) bus ();

  rf_wb_scoreboard #(.D_WIDTH(32), .A_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue_wr(input logic [4:0] rd);
    bus.iss_valid = 1'b1; bus.iss_wr = 1'b1; bus.iss_rd = rd;
    bus.iss_use1 = 1'b0; bus.iss_use2 = 1'b0;
    settle();
    chk($sformatf("iss_ready_rd%0d", rd), {31'd0, bus.iss_ready}, 32'd1);
    tick();
    bus.iss_valid = 1'b0; bus.iss_wr = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    bus.iss_valid = 1'b1; bus.iss_rs1 = 5'd0; bus.iss_rs2 = 5'd0;
    bus.iss_use1 = 1'b0; bus.iss_use2 = 1'b0; bus.iss_wr = 1'b1; bus.iss_rd = 5'd1;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h1;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd2; bus.lsu_data = 32'h2;

    // Reset held for two edges with every requester valid.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_iss_ready", {31'd0, bus.iss_ready}, 32'd0);
      chk("rst_alu_ready", {31'd0, bus.alu_ready}, 32'd0);
      chk("rst_lsu_ready", {31'd0, bus.lsu_ready}, 32'd0);
      chk("rst_rf_we",     {31'd0, bus.rf_we},     32'd0);
      chk("rst_busy",      bus.busy_mask,          32'd0);
      chk("rst_wb_err",    {31'd0, bus.wb_err},    32'd0);
    end
    chk("rst_waddr", {27'd0, bus.rf_waddr}, 32'd0);
    chk("rst_wdata", bus.rf_wdata, 32'd0);
    bus.iss_valid = 1'b0; bus.iss_wr = 1'b0;
    bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Tie arbitration: ALU first after reset, LSU the following cycle.
    issue_wr(5'd3);
    issue_wr(5'd4);
    chk("arb_busy", bus.busy_mask, 32'h0000_0018);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h0000_AAAA;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'h0000_5555;
    settle();
    chk("arb_alu_first", {31'd0, bus.alu_ready}, 32'd1);
    chk("arb_lsu_wait",  {31'd0, bus.lsu_ready}, 32'd0);
    tick();
    bus.alu_valid = 1'b0;
    settle();
    chk("arb_lsu_next", {31'd0, bus.lsu_ready}, 32'd1);
    chk("arb_we1",      {31'd0, bus.rf_we},     32'd1);
    chk("arb_waddr1",   {27'd0, bus.rf_waddr},  32'd3);
    chk("arb_wdata1",   bus.rf_wdata,           32'h0000_AAAA);
    tick();
    bus.lsu_valid = 1'b0;
    settle();
    chk("arb_we2",    {31'd0, bus.rf_we},    32'd1);
    chk("arb_waddr2", {27'd0, bus.rf_waddr}, 32'd4);
    chk("arb_wdata2", bus.rf_wdata,          32'h0000_5555);
    chk("arb_busy_mid", bus.busy_mask,       32'h0000_0010);
    tick();
    chk("arb_we_off",   {31'd0, bus.rf_we},  32'd0);
    chk("arb_busy_end", bus.busy_mask,       32'd0);
    chk("arb_wb_err",   {31'd0, bus.wb_err}, 32'd0);

    // RAW on x5: consumer stalls through the write cycle, released in N+2.
    issue_wr(5'd5);
    chk("raw_busy", bus.busy_mask, 32'h0000_0020);
    bus.iss_valid = 1'b1; bus.iss_rs1 = 5'd5; bus.iss_use1 = 1'b1; bus.iss_wr = 1'b0;
    settle();
    chk("raw_stall0", {31'd0, bus.iss_ready}, 32'd0);
    tick();
    chk("raw_stall1", {31'd0, bus.iss_ready}, 32'd0);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h0000_1234;
    settle();
    chk("raw_grant_n", {31'd0, bus.alu_ready}, 32'd1);
    chk("raw_stall_n", {31'd0, bus.iss_ready}, 32'd0);
    tick();
    bus.alu_valid = 1'b0;
    settle();
    chk("raw_we_n1",    {31'd0, bus.rf_we},     32'd1);
    chk("raw_waddr_n1", {27'd0, bus.rf_waddr},  32'd5);
    chk("raw_wdata_n1", bus.rf_wdata,           32'h0000_1234);
    chk("raw_stall_n1", {31'd0, bus.iss_ready}, 32'd0);
    tick();
    chk("raw_ready_n2", {31'd0, bus.iss_ready}, 32'd1);
    chk("raw_busy_n2",  bus.busy_mask,          32'd0);
    bus.iss_valid = 1'b0; bus.iss_use1 = 1'b0;

    // x0 destination: never busy, write-back granted but not written.
    issue_wr(5'd0);
    chk("x0_busy", bus.busy_mask, 32'd0);
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'hFFFF_FFFF;
    settle();
    chk("x0_lsu_ready", {31'd0, bus.lsu_ready}, 32'd1);
    tick();
    bus.lsu_valid = 1'b0;
    settle();
    chk("x0_rf_we",  {31'd0, bus.rf_we},  32'd0);
    chk("x0_wb_err", {31'd0, bus.wb_err}, 32'd0);

    // WAW stall on x7, then stray write-back to x9 raises sticky wb_err.
    issue_wr(5'd7);
    bus.iss_valid = 1'b1; bus.iss_wr = 1'b1; bus.iss_rd = 5'd7;
    settle();
    chk("waw_stall", {31'd0, bus.iss_ready}, 32'd0);
    bus.iss_valid = 1'b0; bus.iss_wr = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h0000_0099;
    settle();
    chk("err_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
    tick();
    bus.alu_valid = 1'b0;
    settle();
    chk("err_we",    {31'd0, bus.rf_we},    32'd1);
    chk("err_waddr", {27'd0, bus.rf_waddr}, 32'd9);
    chk("err_set",   {31'd0, bus.wb_err},   32'd1);
    tick();
    chk("err_sticky", {31'd0, bus.wb_err}, 32'd1);
    chk("err_busy",   bus.busy_mask,       32'h0000_0080);

    // Mid-operation reset with x1..x3 busy and both requesters waiting.
    issue_wr(5'd1);
    issue_wr(5'd2);
    issue_wr(5'd3);
    chk("mid_busy", bus.busy_mask, 32'h0000_008E);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h0000_0011;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd2; bus.lsu_data = 32'h0000_0022;
    settle();
    chk("mid_rr_lsu", {31'd0, bus.lsu_ready}, 32'd1);
    chk("mid_rr_alu", {31'd0, bus.alu_ready}, 32'd0);
    rst_n = 1'b0;
    settle();
    chk("mid_rst_lsu_ready", {31'd0, bus.lsu_ready}, 32'd0);
    tick();
    chk("mid_rst_busy",   bus.busy_mask,       32'd0);
    chk("mid_rst_we",     {31'd0, bus.rf_we},  32'd0);
    chk("mid_rst_wb_err", {31'd0, bus.wb_err}, 32'd0);
    rst_n = 1'b1;
    settle();
    chk("mid_ptr_alu", {31'd0, bus.alu_ready}, 32'd1);
    chk("mid_ptr_lsu", {31'd0, bus.lsu_ready}, 32'd0);
    tick();
    bus.alu_valid = 1'b0;
    settle();
    chk("mid_lsu_next", {31'd0, bus.lsu_ready}, 32'd1);
    chk("mid_we",       {31'd0, bus.rf_we},     32'd1);
    chk("mid_waddr",    {27'd0, bus.rf_waddr},  32'd1);
    chk("mid_err_again", {31'd0, bus.wb_err},   32'd1);
    tick();
    bus.lsu_valid = 1'b0;
    settle();
    chk("mid_waddr2", {27'd0, bus.rf_waddr}, 32'd2);
    chk("mid_wdata2", bus.rf_wdata,          32'h0000_0022);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end
endmodule
